// File: rtl/fir_xifu_wb.sv
// Writeback/retire stage of the FIR XIFU coprocessor.
// Holds EX/WB entries in a small in-order retire buffer, pairs XFIRLW
// entries with their in-order memory results, and retires each entry by
// writing the XIFU register file and returning a result to the core.
//
// Handshakes: the result channel uses valid/ready. Once result_valid_o is
// high it holds the same id/rd/we/data until result_ready_i is sampled
// high, and the head pops on that edge. The EX side has no valid signal of
// its own: an entry is offered whenever ex_instr_i != NONE and is taken
// only while ex_ready_o is high. ex_ready_o depends on registered state
// only.
module fir_xifu_wb #(
  parameter int ID_WIDTH = 4,
  parameter int DEPTH    = 2,
  parameter int NREGS    = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic [1:0]               ex_instr_i,
  input  logic [ID_WIDTH-1:0]      ex_id_i,
  input  logic [$clog2(NREGS)-1:0] ex_rd_i,
  input  logic [4:0]               ex_rs1_i,
  input  logic [31:0]              ex_result_i,
  output logic                     ex_ready_o,
  input  logic                     mem_result_valid_i,
  input  logic [31:0]              mem_rdata_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [ID_WIDTH-1:0]      result_id_o,
  output logic [4:0]               result_rd_o,
  output logic                     result_we_o,
  output logic [31:0]              result_data_o,
  output logic                     rf_we_o,
  output logic [$clog2(NREGS)-1:0] rf_waddr_o,
  output logic [31:0]              rf_wdata_o,
  output logic                     err_o
);

  localparam int RW = $clog2(NREGS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    I_NONE = 2'd0,
    I_LW   = 2'd1,
    I_SW   = 2'd2,
    I_DOTP = 2'd3
  } instr_e;

  // Retire buffer storage
  logic [1:0]          instr_q [DEPTH];
  logic [ID_WIDTH-1:0] id_q    [DEPTH];
  logic [RW-1:0]       rd_q    [DEPTH];
  logic [4:0]          rs1_q   [DEPTH];
  logic [31:0]         res_q   [DEPTH];
  logic [31:0]         rdata_q [DEPTH];
  logic [DEPTH-1:0]    valid_q;
  logic [DEPTH-1:0]    done_q;

  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic          err_q;

  logic          full;
  logic          enq;
  logic          enq_drop;
  logic          head_valid;
  logic          head_done;
  logic [1:0]    head_instr;
  logic          pop;
  logic          fill_hit;
  logic [PW-1:0] fill_idx;
  logic [PW-1:0] scan_idx;
  logic          fill_new;
  logic          mem_err;

  assign full       = (count_q == CW'(DEPTH));
  assign ex_ready_o = !full;
  assign enq        = (ex_instr_i != I_NONE) && !full && !clear_i;
  assign enq_drop   = (ex_instr_i != I_NONE) && full && !clear_i;

  assign head_valid = valid_q[head_q];
  assign head_done  = done_q[head_q];
  assign head_instr = instr_q[head_q];

  // The head can retire when its data is complete or is arriving right now
  assign result_valid_o = head_valid && (head_done || mem_result_valid_i) && !clear_i;
  assign pop            = result_valid_o && result_ready_i;
  assign err_o          = err_q;

  // Locate the oldest stored LW still waiting for its memory result
  always_comb begin
    fill_hit = 1'b0;
    fill_idx = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (!fill_hit && valid_q[scan_idx] && (instr_q[scan_idx] == I_LW) &&
          !done_q[scan_idx]) begin
        fill_hit = 1'b1;
        fill_idx = scan_idx;
      end
    end
  end

  // With no stored LW pending, the result may belong to the LW entering now
  assign fill_new = mem_result_valid_i && !fill_hit && enq && (ex_instr_i == I_LW);
  assign mem_err  = mem_result_valid_i && !fill_hit && !fill_new && !clear_i;

  // Result channel fields and register-file write, driven from the head
  always_comb begin
    result_id_o   = '0;
    result_rd_o   = '0;
    result_we_o   = 1'b0;
    result_data_o = '0;
    rf_we_o       = 1'b0;
    rf_waddr_o    = '0;
    rf_wdata_o    = '0;
    if (result_valid_o) begin
      result_id_o = id_q[head_q];
      if (head_instr != I_DOTP) begin
        result_we_o   = 1'b1;
        result_rd_o   = rs1_q[head_q];
        result_data_o = res_q[head_q];
      end
    end
    if (pop && (head_instr != I_SW)) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = rd_q[head_q];
      if (head_instr == I_LW) begin
        rf_wdata_o = head_done ? rdata_q[head_q] : mem_rdata_i;
      end else begin
        rf_wdata_o = res_q[head_q];
      end
    end
  end

  // Buffer state: enqueue at tail, memory fill, pop at head, sticky error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        id_q[i]    <= '0;
        rd_q[i]    <= '0;
        rs1_q[i]   <= '0;
        res_q[i]   <= '0;
        rdata_q[i] <= '0;
      end
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (clear_i) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (enq) begin
        instr_q[tail_q] <= ex_instr_i;
        id_q[tail_q]    <= ex_id_i;
        rd_q[tail_q]    <= ex_rd_i;
        rs1_q[tail_q]   <= ex_rs1_i;
        res_q[tail_q]   <= ex_result_i;
        rdata_q[tail_q] <= fill_new ? mem_rdata_i : 32'd0;
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= (ex_instr_i != I_LW) || fill_new;
        tail_q          <= tail_q + PW'(1);
      end
      if (mem_result_valid_i && fill_hit) begin
        rdata_q[fill_idx] <= mem_rdata_i;
        done_q[fill_idx]  <= 1'b1;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      case ({enq, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (enq_drop || mem_err) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_xifu_wb.sv
// Self-checking bench for fir_xifu_wb: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_fir_xifu_wb;

  localparam int IDW   = 4;
  localparam int DEPTH = 2;
  localparam int NREGS = 4;

  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] LW   = 2'd1;
  localparam logic [1:0] SW   = 2'd2;
  localparam logic [1:0] DOTP = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [1:0]  ex_instr;
  logic [3:0]  ex_id;
  logic [1:0]  ex_rd;
  logic [4:0]  ex_rs1;
  logic [31:0] ex_result;
  logic        ex_ready;
  logic        memv;
  logic [31:0] mem_rdata;
  logic        rvalid;
  logic        rready;
  logic [3:0]  rid;
  logic [4:0]  rrd;
  logic        rwe;
  logic [31:0] rdata;
  logic        rf_we;
  logic [1:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        err;

  int tests = 0;
  int fails = 0;

  fir_xifu_wb #(.ID_WIDTH(IDW), .DEPTH(DEPTH), .NREGS(NREGS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .ex_instr_i(ex_instr), .ex_id_i(ex_id), .ex_rd_i(ex_rd), .ex_rs1_i(ex_rs1),
    .ex_result_i(ex_result), .ex_ready_o(ex_ready),
    .mem_result_valid_i(memv), .mem_rdata_i(mem_rdata),
    .result_valid_o(rvalid), .result_ready_i(rready), .result_id_o(rid),
    .result_rd_o(rrd), .result_we_o(rwe), .result_data_o(rdata),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .err_o(err)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear     = 1'b0;
    ex_instr  = NONE;
    ex_id     = '0;
    ex_rd     = '0;
    ex_rs1    = '0;
    ex_result = '0;
    memv      = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic drive_ex(input logic [1:0] ins, input logic [3:0] id, input logic [1:0] rd,
                          input logic [4:0] rs1, input logic [31:0] res);
    ex_instr  = ins;
    ex_id     = id;
    ex_rd     = rd;
    ex_rs1    = rs1;
    ex_result = res;
  endtask

  // Directed vector table
  typedef struct {
    logic [1:0]  instr;
    logic [3:0]  id;
    logic [1:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] res;
    int          delay;
    logic [31:0] mdata;
    logic [4:0]  e_rd;
    logic        e_we;
    logic [31:0] e_data;
    logic        e_rfwe;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vt[5];

  // Scoreboard model: in-order queue of buffered entries
  typedef struct {
    logic [1:0]  instr;
    logic [3:0]  id;
    logic [1:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] res;
    logic        done;
    logic [31:0] mdata;
  } ent_t;

  ent_t mq[$];
  logic m_err;

  initial begin
    vt[0] = '{DOTP, 4'd3, 2'd2, 5'd7,  32'h0000_1234, 0, 32'h0,
              5'd0,  1'b0, 32'h0, 1'b1, 32'h0000_1234};
    vt[1] = '{LW,   4'd1, 2'd1, 5'd10, 32'h0000_1004, 2, 32'hCAFE_F00D,
              5'd10, 1'b1, 32'h0000_1004, 1'b1, 32'hCAFE_F00D};
    vt[2] = '{SW,   4'd5, 2'd3, 5'd31, 32'h0000_2000, 0, 32'h0,
              5'd31, 1'b1, 32'h0000_2000, 1'b0, 32'h0};
    vt[3] = '{LW,   4'd15, 2'd3, 5'd1, 32'hFFFF_FFFC, 0, 32'h8000_0001,
              5'd1,  1'b1, 32'hFFFF_FFFC, 1'b1, 32'h8000_0001};
    vt[4] = '{DOTP, 4'd0, 2'd0, 5'd9,  32'hDEAD_BEEF, 0, 32'h0,
              5'd0,  1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF};

    // Reset with stimulus active
    rst_n  = 1'b0;
    idle();
    rready = 1'b1;
    drive_ex(LW, 4'd7, 2'd1, 5'd3, 32'h55);
    memv      = 1'b1;
    mem_rdata = 32'h1234_5678;
    repeat (3) begin
      #3;
      chk("rst_ready", ex_ready, 1);
      chk("rst_valid", rvalid, 0);
      chk("rst_rfwe", rf_we, 0);
      chk("rst_err", err, 0);
      chk("rst_data", rdata, 0);
      step();
    end
    idle();
    rst_n = 1'b1;
    step();

    // Table-driven single-entry retires
    for (int i = 0; i < 5; i++) begin
      idle();
      rready = 1'b1;
      drive_ex(vt[i].instr, vt[i].id, vt[i].rd, vt[i].rs1, vt[i].res);
      #1;
      chk($sformatf("v%0d_ready", i), ex_ready, 1);
      step();
      idle();
      if (vt[i].instr == LW) begin
        for (int d = 0; d < vt[i].delay; d++) begin
          #1;
          chk($sformatf("v%0d_wait_valid", i), rvalid, 0);
          step();
        end
        memv      = 1'b1;
        mem_rdata = vt[i].mdata;
      end
      #1;
      chk($sformatf("v%0d_valid", i), rvalid, 1);
      chk($sformatf("v%0d_id", i), rid, vt[i].id);
      chk($sformatf("v%0d_rd", i), rrd, vt[i].e_rd);
      chk($sformatf("v%0d_we", i), rwe, vt[i].e_we);
      chk($sformatf("v%0d_data", i), rdata, vt[i].e_data);
      chk($sformatf("v%0d_rfwe", i), rf_we, vt[i].e_rfwe);
      if (vt[i].e_rfwe) begin
        chk($sformatf("v%0d_waddr", i), rf_waddr, vt[i].rd);
        chk($sformatf("v%0d_wdata", i), rf_wdata, vt[i].e_wdata);
      end
      step();
      idle();
      #1;
      chk($sformatf("v%0d_empty_valid", i), rvalid, 0);
      chk($sformatf("v%0d_empty_ready", i), ex_ready, 1);
      step();
    end

    // Backpressure: SW then DOTP held while result_ready is low
    idle();
    rready = 1'b0;
    drive_ex(SW, 4'd2, 2'd0, 5'd5, 32'h0000_0100);
    step();
    drive_ex(DOTP, 4'd4, 2'd1, 5'd0, 32'h0000_0055);
    #1;
    chk("bp_sw_latency", rvalid, 1);
    step();
    idle();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_ready", ex_ready, 0);
      chk("bp_valid", rvalid, 1);
      chk("bp_id", rid, 2);
      chk("bp_data", rdata, 32'h100);
      chk("bp_rfwe", rf_we, 0);
      step();
    end
    rready = 1'b1;
    #1;
    chk("bp_sw_id", rid, 2);
    chk("bp_sw_rd", rrd, 5);
    chk("bp_sw_we", rwe, 1);
    chk("bp_sw_rfwe", rf_we, 0);
    step();
    #1;
    chk("bp_dotp_valid", rvalid, 1);
    chk("bp_dotp_id", rid, 4);
    chk("bp_dotp_we", rwe, 0);
    chk("bp_dotp_data", rdata, 0);
    chk("bp_dotp_rfwe", rf_we, 1);
    chk("bp_dotp_waddr", rf_waddr, 1);
    chk("bp_dotp_wdata", rf_wdata, 32'h55);
    step();
    #1;
    chk("bp_end_valid", rvalid, 0);
    chk("bp_end_ready", ex_ready, 1);
    step();

    // Overflow error, sticky, cleared by clear
    rready = 1'b0;
    drive_ex(DOTP, 4'd6, 2'd0, 5'd0, 32'h6);
    step();
    drive_ex(DOTP, 4'd7, 2'd0, 5'd0, 32'h7);
    step();
    drive_ex(DOTP, 4'd8, 2'd0, 5'd0, 32'h8);
    #1;
    chk("ovf_err_before", err, 0);
    step();
    idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("ovf_err_sticky", err, 1);
      chk("ovf_head_id", rid, 6);
      step();
    end
    clear  = 1'b1;
    rready = 1'b1;
    #1;
    chk("clr_no_retire", rf_we, 0);
    step();
    clear = 1'b0;
    #1;
    chk("clr_err", err, 0);
    chk("clr_ready", ex_ready, 1);
    chk("clr_valid", rvalid, 0);
    // Stray memory result with nothing pending
    memv      = 1'b1;
    mem_rdata = 32'hABCD;
    step();
    memv = 1'b0;
    #1;
    chk("stray_err", err, 1);
    step();
    #1;
    chk("stray_err_sticky", err, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    #1;
    chk("stray_clr_err", err, 0);
    step();

    // Two back-to-back LWs with results on cycles 2 and 4
    rready = 1'b1;
    drive_ex(LW, 4'd9, 2'd2, 5'd3, 32'h40);
    step();
    drive_ex(LW, 4'd10, 2'd3, 5'd4, 32'h44);
    #1;
    chk("b2b_c1_valid", rvalid, 0);
    step();
    idle();
    memv      = 1'b1;
    mem_rdata = 32'h1111_1111;
    #1;
    chk("b2b_a_valid", rvalid, 1);
    chk("b2b_a_id", rid, 9);
    chk("b2b_a_rd", rrd, 3);
    chk("b2b_a_data", rdata, 32'h40);
    chk("b2b_a_waddr", rf_waddr, 2);
    chk("b2b_a_wdata", rf_wdata, 32'h1111_1111);
    step();
    memv = 1'b0;
    #1;
    chk("b2b_c3_valid", rvalid, 0);
    step();
    memv      = 1'b1;
    mem_rdata = 32'h2222_2222;
    #1;
    chk("b2b_b_valid", rvalid, 1);
    chk("b2b_b_id", rid, 10);
    chk("b2b_b_rd", rrd, 4);
    chk("b2b_b_data", rdata, 32'h44);
    chk("b2b_b_waddr", rf_waddr, 3);
    chk("b2b_b_wdata", rf_wdata, 32'h2222_2222);
    step();
    memv = 1'b0;
    #1;
    chk("b2b_end_valid", rvalid, 0);
    chk("b2b_end_err", err, 0);
    clear = 1'b1;
    step();
    idle();

    // Randomized run against the queue model
    mq.delete();
    m_err = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        has_pend;
      logic        e_valid;
      logic        e_rfwe;
      logic        accept;
      logic        new_done;
      logic [31:0] new_data;
      int          pend;
      ent_t        h;
      ent_t        t;

      has_pend = 1'b0;
      foreach (mq[k]) if (mq[k].instr == LW && !mq[k].done) has_pend = 1'b1;

      clear     = ($urandom_range(0, 99) == 0);
      ex_instr  = ($urandom_range(0, 2) == 0) ? NONE : 2'($urandom_range(1, 3));
      ex_id     = 4'($urandom);
      ex_rd     = 2'($urandom);
      ex_rs1    = 5'($urandom);
      ex_result = $urandom;
      memv      = has_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 59) == 0);
      mem_rdata = $urandom;
      rready    = ($urandom_range(0, 3) != 0);
      #1;

      // Expected outputs from the model
      e_valid = !clear && (mq.size() > 0) && (mq[0].done || memv);
      e_rfwe  = 1'b0;
      h       = (mq.size() > 0) ? mq[0] : '{default: '0};
      chk("rnd_ready", ex_ready, (mq.size() < DEPTH));
      chk("rnd_err", err, m_err);
      if (!clear) chk("rnd_valid", rvalid, e_valid);
      if (e_valid) begin
        chk("rnd_id", rid, h.id);
        chk("rnd_we", rwe, (h.instr != DOTP));
        chk("rnd_rd", rrd, (h.instr != DOTP) ? h.rs1 : 5'd0);
        chk("rnd_data", rdata, (h.instr != DOTP) ? h.res : 32'd0);
        e_rfwe = rready && (h.instr != SW);
      end
      chk("rnd_rfwe", rf_we, e_rfwe);
      if (e_rfwe) begin
        chk("rnd_waddr", rf_waddr, h.rd);
        chk("rnd_wdata", rf_wdata,
            (h.instr == LW) ? (h.done ? h.mdata : mem_rdata) : h.res);
      end

      // Model state update for this edge
      if (clear) begin
        mq.delete();
        m_err = 1'b0;
      end else begin
        accept   = (ex_instr != NONE) && (mq.size() < DEPTH);
        new_done = 1'b0;
        new_data = '0;
        if ((ex_instr != NONE) && !accept) m_err = 1'b1;
        pend = -1;
        for (int k = 0; k < mq.size(); k++) begin
          if (pend < 0 && mq[k].instr == LW && !mq[k].done) pend = k;
        end
        if (memv) begin
          if (pend >= 0) begin
            t        = mq[pend];
            t.done   = 1'b1;
            t.mdata  = mem_rdata;
            mq[pend] = t;
          end else if (accept && ex_instr == LW) begin
            new_done = 1'b1;
            new_data = mem_rdata;
          end else begin
            m_err = 1'b1;
          end
        end
        if (accept) begin
          mq.push_back('{ex_instr, ex_id, ex_rd, ex_rs1, ex_result,
                         (ex_instr != LW) || new_done, new_data});
        end
        if (e_valid && rready) void'(mq.pop_front());
      end
      step();
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
